load_store_unit: RTL and testbench

//  RV32I memory stage, directly downstream of the ALU. Consumes the ALU

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit and memory.
//   mem_valid  request held until mem_ready
//   mem_ready  accept/complete; mem_rdata valid in the same cycle
//   mem_we     1 = store
//   mem_addr   word-aligned address
//   mem_wdata  lane-replicated store data
//   mem_wstrb  byte enables (0 for loads)
//   mem_rdata  read data word
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage. Runs one LOAD or STORE per start on a valid/ready bus
// and returns an aligned, extended load result. All outputs are registered.
//   clk, rst            clock, synchronous active-high reset
//   start               request, sampled only when idle
//   instruction         opcode [6:0] and funct3 [14:12] are used
//   address             effective address from the ALU
//   store_data          rs2 value
//   busy                high while the access is in flight or completing
//   done                one-cycle completion pulse
//   load_data           extended load result, held until the next load completes
//   misaligned/illegal/bus_err  status flags, valid with done
//   mem                 data bus (master side)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instruction,
    input  logic [31:0]       address,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              illegal,
    output logic              bus_err,
    load_store_unit_if.master mem
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;

    logic        busy_d, done_d, valid_d, mis_d, ill_d, err_d, we_d;
    logic [31:0] ld_d, addr_d, wdata_d;
    logic [3:0]  wstrb_d;

    // Request decode (only meaningful while idle)
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        is_load, is_store, is_mem, f3_legal, addr_mis, timeout;
    logic [31:0] st_wdata, ld_ext, rd_shift;
    logic [3:0]  st_wstrb;
    logic        unused_insn_bits;

    assign opcode   = instruction[6:0];
    assign f3       = instruction[14:12];
    assign off      = address[1:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign timeout  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign unused_insn_bits = ^{instruction[31:15], instruction[11:7]};

    always_comb begin
        f3_legal = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
    end

    // Access size comes from funct3[1:0] for both loads and stores
    always_comb begin
        addr_mis = 1'b0;
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (f3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                addr_mis = off[0];
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: addr_mis = (off != 2'b00);
        endcase
        if (!is_store) st_wstrb = 4'b0000;
    end

    // Load extract uses the attributes latched at request time
    assign rd_shift = mem.mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (is_mem && f3_legal && !addr_mis) ? S_REQ : S_DONE;
            S_REQ:  if (mem.mem_ready || timeout) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of registered outputs; flags default low so they only
    // live for the single DONE cycle.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        valid_d   = (state_d == S_REQ);
        mis_d     = 1'b0;
        ill_d     = 1'b0;
        err_d     = 1'b0;
        ld_d      = load_data;
        we_d      = mem.mem_we;
        addr_d    = mem.mem_addr;
        wdata_d   = mem.mem_wdata;
        wstrb_d   = mem.mem_wstrb;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        f3_d      = f3_q;
        off_d     = off_q;
        case (state_q)
            S_IDLE: if (start) begin
                is_load_d = is_load;
                f3_d      = f3;
                off_d     = off;
                cnt_d     = 16'd0;
                if (is_mem) begin
                    if (!f3_legal)     ill_d = 1'b1;
                    else if (addr_mis) mis_d = 1'b1;
                    else begin
                        addr_d  = {address[31:2], 2'b00};
                        we_d    = is_store;
                        wdata_d = st_wdata;
                        wstrb_d = st_wstrb;
                    end
                end
            end
            // ready wins over a same-cycle timeout
            S_REQ: begin
                if (mem.mem_ready) begin
                    if (is_load_q) ld_d = ld_ext;
                end else if (timeout) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            load_data     <= 32'h0;
            misaligned    <= 1'b0;
            illegal       <= 1'b0;
            bus_err       <= 1'b0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_wstrb <= 4'h0;
            cnt_q         <= 16'd0;
            is_load_q     <= 1'b0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            load_data     <= ld_d;
            misaligned    <= mis_d;
            illegal       <= ill_d;
            bus_err       <= err_d;
            mem.mem_valid <= valid_d;
            mem.mem_we    <= we_d;
            mem.mem_addr  <= addr_d;
            mem.mem_wdata <= wdata_d;
            mem.mem_wstrb <= wstrb_d;
            cnt_q         <= cnt_d;
            is_load_q     <= is_load_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TO = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] instruction, address, store_data;
    logic        busy, done, misaligned, illegal, bus_err;
    logic [31:0] load_data;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ld = 32'h0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .address(address), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .misaligned(misaligned), .illegal(illegal),
        .bus_err(bus_err), .mem(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load result from the architectural rules
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int o, input logic [31:0] w);
        logic [31:0] s, b, h;
        s = w >> (8 * o);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One access. dly = REQ cycles before mem_ready (-1 = never).
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int dly);
        logic        is_ld, is_st, legal, mis, resp;
        int          o, sz;
        logic [31:0] ew;
        logic [3:0]  es;
        logic [31:0] insn;
        o     = int'(addr[1:0]);
        sz    = 1 << f3[1:0];
        is_ld = (op == LOAD);
        is_st = (op == STORE);
        legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        mis   = (o % sz) != 0;
        insn  = $urandom;
        insn[6:0]   = op;
        insn[14:12] = f3;
        instruction = insn;
        address     = addr;
        store_data  = sdata;
        start       = 1'b1;
        tick();
        start = 1'($urandom);
        if (!(is_ld || is_st) || !legal || mis) begin
            chk("nb_done", done, 1);
            chk("nb_busy", busy, 1);
            chk("nb_valid", bus.mem_valid, 0);
            chk("nb_illegal", illegal, (is_ld || is_st) && !legal);
            chk("nb_misaligned", misaligned, (is_ld || is_st) && legal && mis);
            chk("nb_bus_err", bus_err, 0);
            chk("nb_load_data", load_data, exp_ld);
        end else begin
            ew = sdata;
            es = 4'hF;
            if (sz == 1) begin ew = 32'(sdata[7:0]) * 32'h0101_0101; es = 4'(1 << o); end
            if (sz == 2) begin ew = 32'(sdata[15:0]) * 32'h0001_0001; es = 4'(3 << o); end
            if (is_ld) es = 4'h0;
            for (int k = 0; k < TO; k++) begin
                chk("req_valid", bus.mem_valid, 1);
                chk("req_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk("req_we", bus.mem_we, is_st);
                chk("req_wstrb", bus.mem_wstrb, es);
                if (is_st) chk("req_wdata", bus.mem_wdata, ew);
                chk("req_done", done, 0);
                chk("req_busy", busy, 1);
                bus.mem_ready = (k == dly);
                bus.mem_rdata = (k == dly) ? rdata : $urandom;
                tick();
                bus.mem_ready = 1'b0;
                start = 1'($urandom);
                if (k == dly) break;
            end
            resp = (dly >= 0) && (dly < TO);
            if (resp && is_ld) exp_ld = ref_load(f3, o, rdata);
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 1);
            chk("fin_valid", bus.mem_valid, 0);
            chk("fin_bus_err", bus_err, !resp);
            chk("fin_flags", {illegal, misaligned}, 0);
            chk("fin_load_data", load_data, exp_ld);
        end
        tick();
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_flags", {illegal, misaligned, bus_err}, 0);
        chk("idle_load_data", load_data, exp_ld);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        instruction = 32'h0; address = 32'h0; store_data = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_flags", {illegal, misaligned, bus_err}, 0);
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_bus", {bus.mem_we, bus.mem_wstrb}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(LOAD,  3'd0, 32'h0000_1003, 32'h0,         32'h80FF_0000, 0);  // LB sign
        run_op(STORE, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         0);  // SH upper half
        run_op(LOAD,  3'd2, 32'h0000_3001, 32'h0,         32'h0,         0);  // LW misaligned
        run_op(LOAD,  3'd5, 32'h0000_5000, 32'h0,         32'hDEAD_BEEF, -1); // LHU timeout
        run_op(LOAD,  3'd5, 32'h0000_4002, 32'h0,         32'h8001_0000, 1);  // LHU zext
        run_op(LOAD,  3'd3, 32'h0000_4000, 32'h0,         32'h0,         0);  // illegal funct3
        run_op(STORE, 3'd4, 32'h0000_4000, 32'h0,         32'h0,         0);  // illegal for store
        run_op(7'b0110011, 3'd2, 32'h0,    32'h0,         32'h0,         0);  // non-memory op
        run_op(LOAD,  3'd2, 32'h0000_6004, 32'h0,         32'hCAFE_F00D, TO - 1); // ready on last cycle
        run_op(STORE, 3'd0, 32'h0000_7001, 32'h0000_00A5, 32'h0,         2);  // SB lane 1

        // Reset during REQ abandons the access
        instruction = {17'h0, 3'd2, 5'h0, LOAD};
        address = 32'h0000_8000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rq_valid", bus.mem_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ld = 32'h0;
        chk("rq_rst_valid", bus.mem_valid, 0);
        chk("rq_rst_busy", busy, 0);
        chk("rq_rst_done", done, 0);
        chk("rq_rst_load_data", load_data, exp_ld);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rq_no_done", done, 0);
        end
        run_op(STORE, 3'd2, 32'h0000_9008, 32'h0BAD_CAFE, 32'h0, 0);

        // Randomized accesses
        for (int i = 0; i < 120; i++) begin
            int          r, d;
            logic [6:0]  op;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? LOAD : (r < 8) ? STORE : (r == 8) ? 7'b0010011 : 7'b1100011;
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[0] = 1'b0;
            d  = int'($urandom_range(0, 4));
            if (d == 4) d = -1;
            run_op(op, 3'($urandom_range(0, 7)), a, $urandom, $urandom, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
